// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: decoder/ALU/TX/RX/prefetch signals of the stage sequencer; master drives instruction+handshake inputs, slave (sequencer) drives stage/control outputs
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int STAGE_BITS = $clog2(NUM_STAGES)
);
  logic inst_valid, inst_done;
  logic [NUM_STAGES-1:0] stage_mask, stage_send_cmd, stage_wait_rx, stage_access_pc;
  logic need_imm, imm_loaded, load_imm, use_cc, cond_ok, op_done, prefetch_idle;
  logic tx_command_started, tx_data_next, rx_started, rx_data_valid;
  logic [STAGE_BITS-1:0] stage;
  logic [NUM_STAGES-1:0] stage_onehot;
  logic execute, tx_command_valid, command_active, block_prefetch, alu_en;
  modport master (
    output inst_valid, stage_mask, stage_send_cmd, stage_wait_rx, stage_access_pc, need_imm, imm_loaded,
           use_cc, cond_ok, op_done, prefetch_idle, tx_command_started, tx_data_next, rx_started, rx_data_valid,
    input  inst_done, load_imm, stage, stage_onehot, execute, tx_command_valid, command_active, block_prefetch, alu_en
  );
  modport slave (
    input  inst_valid, stage_mask, stage_send_cmd, stage_wait_rx, stage_access_pc, need_imm, imm_loaded,
           use_cc, cond_ok, op_done, prefetch_idle, tx_command_started, tx_data_next, rx_started, rx_data_valid,
    output inst_done, load_imm, stage, stage_onehot, execute, tx_command_valid, command_active, block_prefetch, alu_en
  );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: steps one instruction through its masked stages; ports clk, reset (async high), bus (slave: decoder handshake, imm/cc, ALU/TX/RX/prefetch gating)
module stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int IMM_WORDS = 1,
  parameter int STAGE_BITS = $clog2(NUM_STAGES)
) (
  input logic clk,
  input logic reset,
  stage_sequencer_if.slave bus
);
  localparam int IW = $clog2(IMM_WORDS + 1);
  logic [STAGE_BITS-1:0] cur_stage, s, hi;
  logic [IW-1:0] imm_count;
  logic cmd_q, rx_seen, none, last, act, need_more_imm, skip, run, both_wait, rx_block;
  always_comb begin
    s = cur_stage;
    hi = '0;
    none = 1'b1;
    for (int i = NUM_STAGES - 1; i >= 0; i--)
      if (bus.stage_mask[i] && STAGE_BITS'(i) >= cur_stage) begin
        s = STAGE_BITS'(i);
        none = 1'b0;
      end
    for (int i = 0; i < NUM_STAGES; i++)
      if (bus.stage_mask[i]) hi = STAGE_BITS'(i);
  end
  assign last = s == hi;
  assign act = bus.inst_valid && !reset;
  assign need_more_imm = bus.need_imm && imm_count < IW'(IMM_WORDS);
  assign skip = bus.use_cc && !bus.cond_ok;
  assign run = act && !need_more_imm && !skip && !none;
  assign both_wait = bus.stage_access_pc[s] && !bus.prefetch_idle;
  assign rx_block = bus.stage_wait_rx[s] && !(bus.rx_started || rx_seen);
  assign bus.inst_done = act && !need_more_imm && (skip || none || (bus.op_done && last));
  assign bus.load_imm = act && need_more_imm;
  assign bus.execute = run;
  assign bus.tx_command_valid = run && bus.stage_send_cmd[s] && !cmd_q && !both_wait && !rx_block;
  assign bus.alu_en = run && !both_wait && !(bus.stage_wait_rx[s] && !bus.rx_data_valid)
                      && !(bus.stage_send_cmd[s] && !(cmd_q && bus.tx_data_next));
  assign bus.block_prefetch = run && bus.stage_access_pc[s];
  assign bus.command_active = act && cmd_q;
  assign bus.stage = reset ? '0 : s;
  assign bus.stage_onehot = act && !none ? NUM_STAGES'(1) << s : '0;
  // op_done advance takes priority over a same-cycle command start
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur_stage <= '0;
      imm_count <= '0;
      cmd_q <= 1'b0;
      rx_seen <= 1'b0;
    end else if (bus.inst_done) begin
      cur_stage <= '0;
      imm_count <= '0;
      cmd_q <= 1'b0;
      rx_seen <= 1'b0;
    end else if (bus.inst_valid) begin
      if (bus.imm_loaded && imm_count < IW'(IMM_WORDS)) imm_count <= imm_count + 1'b1;
      if (run && bus.op_done) begin
        cur_stage <= s + 1'b1;
        cmd_q <= 1'b0;
        rx_seen <= 1'b0;
      end else begin
        if (bus.tx_command_started) cmd_q <= 1'b1;
        if (bus.rx_started && bus.stage_wait_rx[s] && !none) rx_seen <= 1'b1;
      end
    end
endmodule
